// File: rtl/knn_pkg.sv
// knn_pkg: sequencer state encoding, neighbour count and width helpers
// shared by the KNN controller, its counter block and its interface.
package knn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CAPT  = 3'd2,
        S_FEED  = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } knn_state_e;

    localparam int K      = 4;
    localparam int RANK_W = 2;

    function automatic int coord_w(input int w);
        return w / 2;
    endfunction

    function automatic int idx_w(input int w);
        return w / 4;
    endfunction

endpackage

// File: rtl/knn_ctrl_if.sv
// knn_ctrl_if: host, point-memory, sorter and result-port signals of the
// KNN sequencer; master is the controller side, slave is the environment.
interface knn_ctrl_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 8
);
    import knn_pkg::*;

    localparam int CW = coord_w(W);
    localparam int IW = idx_w(W);

    logic              start;
    logic [ADDR_W-1:0] n_train;
    logic [ADDR_W-1:0] n_test;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] test_addr;
    logic [W-1:0]      test_data;
    logic [ADDR_W-1:0] train_addr;
    logic [W-1:0]      train_data;
    logic              sorter_rst;
    logic              sorter_ready;
    logic              sorter_done;
    logic [RANK_W-1:0] sorter_sel;
    logic [CW-1:0]     sorter_x1;
    logic [CW-1:0]     sorter_y1;
    logic [CW-1:0]     sorter_x2;
    logic [CW-1:0]     sorter_y2;
    logic [IW-1:0]     sorter_idx;
    logic              res_we;
    logic [ADDR_W+1:0] res_addr;
    logic [IW-1:0]     res_data;

    modport master (
        input  start, n_train, n_test, test_data, train_data, sorter_idx,
        output busy, done, test_addr, train_addr, sorter_rst, sorter_ready,
               sorter_done, sorter_sel, sorter_x1, sorter_y1, sorter_x2,
               sorter_y2, res_we, res_addr, res_data
    );

    modport slave (
        output start, n_train, n_test, test_data, train_data, sorter_idx,
        input  busy, done, test_addr, train_addr, sorter_rst, sorter_ready,
               sorter_done, sorter_sel, sorter_x1, sorter_y1, sorter_x2,
               sorter_y2, res_we, res_addr, res_data
    );

endinterface

// File: rtl/knn_ctrl_cnt.sv
// knn_ctrl_cnt: test-point and training-point index counters with
// clear/enable and the compares the sequencer branches on.
module knn_ctrl_cnt #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_n_train,
    input  logic [ADDR_W-1:0] i_n_test,
    input  logic              i_test_clr,
    input  logic              i_test_en,
    input  logic              i_train_clr,
    input  logic              i_train_en,
    output logic [ADDR_W-1:0] o_test_idx,
    output logic [ADDR_W-1:0] o_train_idx,
    output logic              o_test_last,
    output logic              o_train_run
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_test_idx;
    logic [ADDR_W-1:0] r_train_idx;
    logic [ADDR_W-1:0] w_test_inc;

    assign w_test_inc = r_test_idx + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_test_idx  <= '0;
            r_train_idx <= '0;
        end else begin
            if (i_test_clr)
                r_test_idx <= '0;
            else if (i_test_en)
                r_test_idx <= w_test_inc;

            if (i_train_clr)
                r_train_idx <= '0;
            else if (i_train_en)
                r_train_idx <= r_train_idx + ONE;
        end
    end

    // n_test is never zero while the test counter is stepping, so no wrap case
    assign o_test_last = (w_test_inc == i_n_test);
    assign o_train_run = (r_train_idx < i_n_train);
    assign o_test_idx  = r_test_idx;
    assign o_train_idx = r_train_idx;

endmodule

// File: rtl/knn_ctrl.sv
// knn_ctrl: KNN insertion-sorter sequencer (load test point, stream training
// points, drain 4 ranks). Optional irq/irq_ack ports under `KNN_CTRL_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for start, counts latched on accept
// LOAD  | test memory addressed with test_idx
// CAPT  | test point registered, sorter cleared
// FEED  | one training point issued per cycle, ready trails by one
// DRAIN | rank r selected and written to the result memory
// NEXT  | advance to next test point or finish
// FIN   | done pulse
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int W      = 32,
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    knn_ctrl_if.master bus
`ifdef KNN_CTRL_IRQ_EN
    ,
    input  logic       irq_ack,
    output logic       irq
`endif
);

    localparam int CW = coord_w(W);

    knn_state_e        r_state;
    knn_state_e        w_next;
    logic [ADDR_W-1:0] r_n_train;
    logic [ADDR_W-1:0] r_n_test;
    logic [CW-1:0]     r_x1;
    logic [CW-1:0]     r_y1;
    logic [RANK_W-1:0] r_rank;
    logic              r_ready;

    logic [ADDR_W-1:0] w_test_idx;
    logic [ADDR_W-1:0] w_train_idx;
    logic              w_test_last;
    logic              w_train_run;
    logic              w_accept;
    logic              w_issue;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_issue  = (r_state == S_FEED) && w_train_run;

    knn_ctrl_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_n_train   (r_n_train),
        .i_n_test    (r_n_test),
        .i_test_clr  (w_accept),
        .i_test_en   (r_state == S_NEXT),
        .i_train_clr (r_state == S_CAPT),
        .i_train_en  (w_issue),
        .o_test_idx  (w_test_idx),
        .o_train_idx (w_train_idx),
        .o_test_last (w_test_last),
        .o_train_run (w_train_run)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_n_train <= '0;
            r_n_test  <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_rank    <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_issue;
            if (w_accept) begin
                r_n_train <= bus.n_train;
                r_n_test  <= bus.n_test;
            end
            if (r_state == S_CAPT) begin
                r_x1 <= bus.test_data[W-1:CW];
                r_y1 <= bus.test_data[CW-1:0];
            end
            if (r_state == S_DRAIN)
                r_rank <= r_rank + RANK_W'(1);
            else
                r_rank <= '0;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.busy        = (r_state != S_IDLE);
        bus.done        = 1'b0;
        bus.test_addr   = '0;
        bus.train_addr  = '0;
        bus.sorter_rst  = 1'b0;
        bus.sorter_done = 1'b1;
        bus.sorter_sel  = '0;
        bus.res_we      = 1'b0;
        bus.res_addr    = '0;
        bus.res_data    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (bus.n_test == '0) ? S_FIN : S_LOAD;
            end
            S_LOAD: begin
                bus.test_addr = w_test_idx;
                w_next        = S_CAPT;
            end
            S_CAPT: begin
                bus.sorter_rst = 1'b1;
                w_next         = S_FEED;
            end
            S_FEED: begin
                bus.sorter_done = 1'b0;
                // the cycle with no issue is the one carrying the final ready
                if (w_train_run)
                    bus.train_addr = w_train_idx;
                else
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                bus.sorter_sel = r_rank;
                bus.res_we     = 1'b1;
                bus.res_addr   = {w_test_idx, r_rank};
                bus.res_data   = bus.sorter_idx;
                if (r_rank == RANK_W'(K - 1))
                    w_next = S_NEXT;
            end
            S_NEXT: begin
                w_next = w_test_last ? S_FIN : S_LOAD;
            end
            S_FIN: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.sorter_ready = r_ready;
    assign bus.sorter_x1    = r_x1;
    assign bus.sorter_y1    = r_y1;
    assign bus.sorter_x2    = r_ready ? bus.train_data[W-1:CW] : '0;
    assign bus.sorter_y2    = r_ready ? bus.train_data[CW-1:0] : '0;

`ifdef KNN_CTRL_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst)
            r_irq <= 1'b0;
        else if (r_state == S_FIN)
            r_irq <= 1'b1;
        else if (irq_ack || w_accept)
            r_irq <= 1'b0;
    end

    // visible in the FIN cycle itself so it rises together with done
    assign irq = r_irq || (r_state == S_FIN);
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: drives the KNN sequencer against point memories and a
// behavioural sorter; results are compared with a direct nearest-4 model.
module tb_knn_ctrl;

    localparam int W  = 32;
    localparam int AW = 8;

    typedef struct { int addr; int data; } wr_t;

    localparam logic [105:0] RST_VEC = {1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1,
                                        2'd0, 64'd0, 1'b0, 10'd0, 8'd0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_ctrl_if #(.W(W), .ADDR_W(AW)) bus ();

`ifdef KNN_CTRL_IRQ_EN
    logic irq_ack;
    logic irq;
    bit   ack_fin;
    logic irq_at_done;
    logic irq_k2;
`endif

    knn_ctrl #(.W(W), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef KNN_CTRL_IRQ_EN
        ,
        .irq_ack (irq_ack),
        .irq     (irq)
`endif
    );

    logic [W-1:0] test_mem  [256];
    logic [W-1:0] train_mem [256];
    int           sd [4];
    logic [7:0]   si [4];
    int           scnt;

    int  n_vec = 0;
    int  n_bad = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    int  n_ready, first_ready, n_srst, done_cyc, n_done;

    function automatic int dist2(input logic [W-1:0] a, input logic [W-1:0] b);
        int dx, dy;
        dx = int'($signed(a[31:16])) - int'($signed(b[31:16]));
        dy = int'($signed(a[15:0]))  - int'($signed(b[15:0]));
        return dx * dx + dy * dy;
    endfunction

    function automatic logic [W-1:0] pt(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    function automatic int rc();
        return int'($urandom_range(40)) - 20;
    endfunction

    always @(posedge clk) begin
        bus.test_data  <= test_mem[bus.test_addr];
        bus.train_data <= train_mem[bus.train_addr];
    end

    // behavioural sorter: keeps the 4 smallest distances, earlier wins on ties
    always @(posedge clk) begin
        int   d, p;
        int   nd [4];
        logic [7:0] ni [4];
        if (rst || bus.sorter_rst) begin
            for (int j = 0; j < 4; j++) begin
                sd[j] <= 32'h7fff_ffff;
                si[j] <= 8'd0;
            end
            scnt <= 0;
        end else if (bus.sorter_ready && !bus.sorter_done) begin
            d  = dist2({bus.sorter_x1, bus.sorter_y1}, {bus.sorter_x2, bus.sorter_y2});
            nd = sd;
            ni = si;
            p  = 4;
            for (int j = 3; j >= 0; j--)
                if (d < sd[j]) p = j;
            if (p < 4) begin
                for (int j = 3; j > p; j--) begin
                    nd[j] = sd[j-1];
                    ni[j] = si[j-1];
                end
                nd[p] = d;
                ni[p] = scnt[7:0];
            end
            sd   <= nd;
            si   <= ni;
            scnt <= scnt + 1;
        end
    end

    assign bus.sorter_idx = si[bus.sorter_sel];

    function automatic logic [105:0] out_vec();
        return {bus.busy, bus.done, bus.test_addr, bus.train_addr, bus.sorter_rst,
                bus.sorter_ready, bus.sorter_done, bus.sorter_sel, bus.sorter_x1,
                bus.sorter_y1, bus.sorter_x2, bus.sorter_y2, bus.res_we,
                bus.res_addr, bus.res_data};
    endfunction

    // for each test point: pick the 4 closest training points by index order
    function automatic void build_expected(input int ntest, input int ntrain);
        int d [256];
        bit used [256];
        int best;
        exp_q.delete();
        for (int t = 0; t < ntest; t++) begin
            for (int i = 0; i < 256; i++) used[i] = 1'b0;
            for (int i = 0; i < ntrain; i++) d[i] = dist2(test_mem[t], train_mem[i]);
            for (int r = 0; r < 4; r++) begin
                best = -1;
                for (int i = 0; i < ntrain; i++)
                    if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
                if (best >= 0) used[best] = 1'b1;
                exp_q.push_back('{t * 4 + r, (best < 0) ? 0 : best});
            end
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= obs_q.size() || i >= exp_q.size() ||
                obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data)
                return i;
        return -1;
    endfunction

    // start in cycle 0, extra start pulses at poke_at and in the FIN cycle
    task automatic run(input int ntest, input int ntrain, input bit scramble, input int poke_at);
        int limit;
        limit = ntest * (ntrain + 8) + 6;
        obs_q.delete();
        n_ready = 0; first_ready = -1; n_srst = 0; done_cyc = -1; n_done = 0;
        bus.n_test  = ntest[7:0];
        bus.n_train = ntrain[7:0];
        @(negedge clk);
        for (int k = 0; k < limit; k++) begin
            if (bus.res_we) obs_q.push_back('{int'(bus.res_addr), int'(bus.res_data)});
            if (bus.sorter_ready) begin
                n_ready++;
                if (first_ready < 0) first_ready = k;
            end
            if (bus.sorter_rst) n_srst++;
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
`ifdef KNN_CTRL_IRQ_EN
            if (k == 2) irq_k2 = irq;
            if (bus.done && done_cyc == k) irq_at_done = irq;
            irq_ack = ack_fin && bus.done;
`endif
            bus.start = (k == 0) || (k == poke_at) || (done_cyc == k);
            if (scramble && k > 0) begin
                bus.n_test  = 8'($urandom);
                bus.n_train = 8'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
`ifdef KNN_CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
        end
        n_vec++;
        if (bus.sorter_done !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_sorter_done: got %b want 1", bus.sorter_done);
        end
`ifdef KNN_CTRL_IRQ_EN
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed_six();
        int want [4] = '{0, 2, 4, 5};
        train_mem[0] = pt(0, 0); train_mem[1] = pt(5, 5); train_mem[2] = pt(1, 1);
        train_mem[3] = pt(9, 9); train_mem[4] = pt(2, 0); train_mem[5] = pt(0, 3);
        test_mem[0]  = pt(0, 0);
        run(1, 6, 1'b0, 7);
        n_vec++;
        if (done_cyc !== 15) begin
            n_bad++;
            $display("FAIL six_done_cycle: got %0d want 15", done_cyc);
        end
        n_vec++;
        if (obs_q.size() !== 4) begin
            n_bad++;
            $display("FAIL six_write_count: got %0d want 4", obs_q.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                n_vec++;
                if (obs_q[r].addr !== r || obs_q[r].data !== want[r]) begin
                    n_bad++;
                    $display("FAIL six_rank%0d: got addr %0d idx %0d want addr %0d idx %0d",
                             r, obs_q[r].addr, obs_q[r].data, r, want[r]);
                end
            end
        end
        n_vec++;
        if (first_ready !== 4 || n_ready !== 6) begin
            n_bad++;
            $display("FAIL six_ready: got first %0d count %0d want first 4 count 6",
                     first_ready, n_ready);
        end
        n_vec++;
        if (n_done !== 1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL six_restart: got dones %0d busy %b want 1 and 0", n_done, bus.busy);
        end
    endtask

    task automatic test_three_by_four();
        int bad_addr, mask;
        for (int i = 0; i < 4; i++) train_mem[i] = pt(rc(), rc());
        for (int t = 0; t < 3; t++) test_mem[t] = pt(rc(), rc());
        build_expected(3, 4);
        run(3, 4, 1'b1, 20);
        n_vec++;
        if (done_cyc !== 37) begin
            n_bad++;
            $display("FAIL t3n4_done_cycle: got %0d want 37", done_cyc);
        end
        n_vec++;
        if (obs_q.size() !== 12) begin
            n_bad++;
            $display("FAIL t3n4_write_count: got %0d want 12", obs_q.size());
        end else begin
            bad_addr = 0;
            for (int i = 0; i < 12; i++) if (obs_q[i].addr != i) bad_addr++;
            n_vec++;
            if (bad_addr !== 0) begin
                n_bad++;
                $display("FAIL t3n4_addr_contig: got %0d bad addresses want 0", bad_addr);
            end
            for (int t = 0; t < 3; t++) begin
                mask = 0;
                for (int r = 0; r < 4; r++) mask |= 1 << obs_q[t*4+r].data;
                n_vec++;
                if (mask !== 15) begin
                    n_bad++;
                    $display("FAIL t3n4_perm%0d: got mask %h want f", t, mask);
                end
            end
        end
        n_vec++;
        if (first_diff() !== -1) begin
            n_bad++;
            $display("FAIL t3n4_model: got first diff at %0d want none", first_diff());
        end
    endtask

    task automatic test_short_train();
        int want [4] = '{1, 0, 0, 0};
        train_mem[0] = pt(3, 0); train_mem[1] = pt(1, 0);
        test_mem[0]  = pt(0, 0);
        run(1, 2, 1'b0, -1);
        n_vec++;
        if (obs_q.size() !== 4) begin
            n_bad++;
            $display("FAIL short_write_count: got %0d want 4", obs_q.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                n_vec++;
                if (obs_q[r].data !== want[r]) begin
                    n_bad++;
                    $display("FAIL short_rank%0d: got %0d want %0d", r, obs_q[r].data, want[r]);
                end
            end
        end
        n_vec++;
        if (n_ready > 2) begin
            n_bad++;
            $display("FAIL short_ready_count: got %0d want at most 2", n_ready);
        end
    endtask

    task automatic test_zero_test();
        run(0, 5, 1'b1, -1);
        n_vec++;
        if (done_cyc !== 1) begin
            n_bad++;
            $display("FAIL zero_done_cycle: got %0d want 1", done_cyc);
        end
        n_vec++;
        if (obs_q.size() !== 0 || n_ready !== 0 || n_srst !== 0) begin
            n_bad++;
            $display("FAIL zero_activity: got we %0d ready %0d srst %0d want 0 0 0",
                     obs_q.size(), n_ready, n_srst);
        end
    endtask

    task automatic test_random();
        int nt, ntr;
        for (int it = 0; it < 6; it++) begin
            nt  = 1 + int'($urandom_range(2));
            ntr = int'($urandom_range(12));
            for (int i = 0; i < ntr; i++) train_mem[i] = pt(rc(), rc());
            for (int t = 0; t < nt; t++) test_mem[t] = pt(rc(), rc());
            build_expected(nt, ntr);
            run(nt, ntr, 1'($urandom), 3);
            n_vec++;
            if (done_cyc !== nt * (ntr + 8) + 1) begin
                n_bad++;
                $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, done_cyc, nt * (ntr + 8) + 1);
            end
            n_vec++;
            if (first_diff() !== -1) begin
                n_bad++;
                $display("FAIL rand%0d_model: got first diff at %0d want none", it, first_diff());
            end
            n_vec++;
            if (n_ready !== nt * ntr || n_srst !== nt) begin
                n_bad++;
                $display("FAIL rand%0d_strobes: got ready %0d srst %0d want %0d %0d",
                         it, n_ready, n_srst, nt * ntr, nt);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        logic busy_mid;
        for (int i = 0; i < 10; i++) train_mem[i] = pt(rc(), rc());
        test_mem[0] = pt(rc(), rc());
        test_mem[1] = pt(rc(), rc());
        bus.n_test  = 8'd2;
        bus.n_train = 8'd10;
        busy_mid    = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) busy_mid = bus.busy;
            bus.start = (k == 0) || (k == 2);
            rst       = (k == 5);
            @(negedge clk);
        end
        n_vec++;
        if (busy_mid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_busy_before: got %b want 1", busy_mid);
        end
        n_vec++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h want %h", out_vec(), RST_VEC);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        seen      = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy || bus.done) seen++;
            @(negedge clk);
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midrst_idle: got %0d active cycles want 0", seen);
        end
    endtask

`ifdef KNN_CTRL_IRQ_EN
    task automatic test_irq();
        test_mem[0]  = pt(1, 1);
        train_mem[0] = pt(2, 2);
        ack_fin = 1'b0;
        run(1, 1, 1'b0, -1);
        n_vec++;
        if (irq_at_done !== 1'b1 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set_hold: got at_done %b later %b want 1 1", irq_at_done, irq);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_ack_clear: got %b want 0", irq);
        end
        ack_fin = 1'b1;
        run(1, 1, 1'b0, -1);
        ack_fin = 1'b0;
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set_wins: got %b want 1", irq);
        end
        run(1, 1, 1'b0, -1);
        n_vec++;
        if (irq_k2 !== 1'b0 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_start_clear: got mid %b end %b want 0 1", irq_k2, irq);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.n_test  = 8'd0;
        bus.n_train = 8'd0;
`ifdef KNN_CTRL_IRQ_EN
        irq_ack = 1'b0;
        ack_fin = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            test_mem[i]  = '0;
            train_mem[i] = '0;
        end
        test_reset();
        test_directed_six();
        test_three_by_four();
        test_short_train();
        test_zero_test();
        test_random();
        test_reset_midrun();
`ifdef KNN_CTRL_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
